// File: rtl/key_press_conditioner.sv
// rtl/key_press_conditioner.sv - debounced key level and press/release strobes from raw active-low buttons
//
// Purpose: per-key 2-FF synchronizer followed by an independent debounce FSM.
//          Every output is registered. The output stage adds one cycle after the
//          FSM accepts a change, so the fixed latency is DEBOUNCE_CYCLES+3 cycles.
// Optional feature: define KEY_AUTOREPEAT_EN to add auto-repeat press strobes
//          while a key stays held (parameters REPEAT_DELAY, REPEAT_PERIOD).
// Ports:
//   i_clk            system clock
//   i_hard_reset     synchronous active-high reset
//   i_key_n          raw asynchronous button lines, 0 = pressed
//   o_pressed        debounced level, 1 = key held
//   o_press_pulse    one-cycle strobe on an accepted press (and on repeats)
//   o_release_pulse  one-cycle strobe on an accepted release

module key_press_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic                i_clk,
    input  logic                i_hard_reset,
    input  logic [NUM_KEYS-1:0] i_key_n,
    output logic [NUM_KEYS-1:0] o_pressed,
    output logic [NUM_KEYS-1:0] o_press_pulse,
    output logic [NUM_KEYS-1:0] o_release_pulse
);

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two-stage synchronizer; reset to the released level (1).
    logic [NUM_KEYS-1:0] sync_a;
    logic [NUM_KEYS-1:0] s_n;

    always_ff @(posedge i_clk) begin
        if (i_hard_reset) begin
            sync_a <= '1;
            s_n    <= '1;
        end else begin
            sync_a <= i_key_n;
            s_n    <= sync_a;
        end
    end

    // Next values for the registered outputs, one bit per key.
    logic [NUM_KEYS-1:0] pressed_d;
    logic [NUM_KEYS-1:0] press_d;
    logic [NUM_KEYS-1:0] release_d;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        state_t           state;
        state_t           state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             held;
        logic             press_evt;
        logic             release_evt;
        logic             repeat_hit;

        // State register
        always_ff @(posedge i_clk) begin
            if (i_hard_reset) begin
                state <= ST_RELEASED;
                cnt   <= '0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
            end
        end

        // Next-state logic
        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            case (state)
                ST_RELEASED: begin
                    cnt_next = '0;
                    if (!s_n[g]) begin
                        state_next = ST_PRESS_CHK;
                        cnt_next   = CNT_ONE;
                    end
                end
                ST_PRESS_CHK: begin
                    if (s_n[g]) begin
                        state_next = ST_RELEASED;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = ST_PRESSED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    cnt_next = '0;
                    if (s_n[g]) begin
                        state_next = ST_RELEASE_CHK;
                        cnt_next   = CNT_ONE;
                    end
                end
                ST_RELEASE_CHK: begin
                    if (!s_n[g]) begin
                        state_next = ST_PRESSED;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = ST_RELEASED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_RELEASED;
                    cnt_next   = '0;
                end
            endcase
        end

`ifdef KEY_AUTOREPEAT_EN
        localparam int REP_W = $clog2(REPEAT_DELAY + 1);
        localparam logic [REP_W-1:0] REP_HIT  = REP_W'(REPEAT_DELAY);
        // Reloading to DELAY-PERIOD+1 makes the next hit land PERIOD cycles later.
        localparam logic [REP_W-1:0] REP_LOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        logic [REP_W-1:0] rep_cnt;

        always_ff @(posedge i_clk) begin
            if (i_hard_reset || state != ST_PRESSED) begin
                rep_cnt <= '0;
            end else if (rep_cnt == REP_HIT) begin
                rep_cnt <= REP_LOAD;
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end

        assign repeat_hit = (state == ST_PRESSED) && (rep_cnt == REP_HIT);
`else
        assign repeat_hit = 1'b0;
`endif

        // Output logic: the registered level trails the FSM by one cycle, so a
        // disagreement between them marks the accepted edge exactly once.
        always_comb begin
            held        = (state == ST_PRESSED) || (state == ST_RELEASE_CHK);
            press_evt   = (held && !o_pressed[g]) || repeat_hit;
            release_evt = !held && o_pressed[g];
        end

        assign pressed_d[g] = held;
        assign press_d[g]   = press_evt;
        assign release_d[g] = release_evt;
    end

    always_ff @(posedge i_clk) begin
        if (i_hard_reset) begin
            o_pressed       <= '0;
            o_press_pulse   <= '0;
            o_release_pulse <= '0;
        end else begin
            o_pressed       <= pressed_d;
            o_press_pulse   <= press_d;
            o_release_pulse <= release_d;
        end
    end

endmodule

// File: tb/tb_key_press_conditioner.sv
// tb/tb_key_press_conditioner.sv - directed self-checking bench for key_press_conditioner

module tb_key_press_conditioner;

    localparam int NK = 4;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] pressed;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;

    int checks   = 0;
    int failures = 0;
    int press_cnt   [NK] = '{default: 0};
    int release_cnt [NK] = '{default: 0};
    int p_snap;
    int r_snap;

    always #5 clk = ~clk;

    key_press_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (6)
`endif
    ) dut (
        .i_clk           (clk),
        .i_hard_reset    (rst),
        .i_key_n         (key_n),
        .o_pressed       (pressed),
        .o_press_pulse   (press_pulse),
        .o_release_pulse (release_pulse)
    );

    // Pulse tallies sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NK; i++) begin
            press_cnt[i]   += int'(press_pulse[i]);
            release_cnt[i] += int'(release_pulse[i]);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 4'b1111;
        tick(3);
        check_eq("rst_pressed", pressed, 4'b0000);
        check_eq("rst_press", press_pulse, 4'b0000);
        check_eq("rst_release", release_pulse, 4'b0000);
        rst = 1'b0;

        // Clean press / release of key0: pulse 11 cycles after the input change.
        key_n[0] = 1'b0;
        tick(10);
        check_eq("k0_press_early", press_pulse, 4'b0000);
        check_eq("k0_level_early", pressed, 4'b0000);
        tick(1);
        check_eq("k0_press", press_pulse, 4'b0001);
        check_eq("k0_level", pressed, 4'b0001);
        tick(1);
        check_eq("k0_press_once", press_pulse, 4'b0000);
        check_eq("k0_level_hold", pressed, 4'b0001);
        key_n[0] = 1'b1;
        tick(10);
        check_eq("k0_rel_early", release_pulse, 4'b0000);
        check_eq("k0_rel_level_early", pressed, 4'b0001);
        tick(1);
        check_eq("k0_release", release_pulse, 4'b0001);
        check_eq("k0_rel_level", pressed, 4'b0000);
        check_eq("k0_no_press_on_rel", press_pulse, 4'b0000);
        tick(5);

        // Bouncy press of key1.
        p_snap = press_cnt[1];
        key_n[1] = 1'b0; tick(5);
        key_n[1] = 1'b1; tick(1);
        key_n[1] = 1'b0; tick(5);
        key_n[1] = 1'b1; tick(1);
        key_n[1] = 1'b0;
        tick(10);
        check_eq("k1_bounce_none", press_cnt[1] - p_snap, 0);
        check_eq("k1_bounce_early", press_pulse, 4'b0000);
        tick(1);
        check_eq("k1_bounce_press", press_pulse, 4'b0010);
        key_n[1] = 1'b1;
        tick(11);
        check_eq("k1_release", release_pulse, 4'b0010);
        tick(3);

        // Long hold of key2: one press, one release.
        p_snap = press_cnt[2];
        r_snap = release_cnt[2];
        key_n[2] = 1'b0;
        tick(200);
        check_eq("k2_hold_one_press", press_cnt[2] - p_snap, 1);
        check_eq("k2_hold_level", pressed, 4'b0100);
        key_n[2] = 1'b1;
        tick(10);
        check_eq("k2_rel_early", release_pulse, 4'b0000);
        check_eq("k2_rel_level_early", pressed, 4'b0100);
        tick(1);
        check_eq("k2_release", release_pulse, 4'b0100);
        check_eq("k2_rel_level", pressed, 4'b0000);
        tick(2);
        check_eq("k2_total_press", press_cnt[2] - p_snap, 1);
        check_eq("k2_total_release", release_cnt[2] - r_snap, 1);

        // Two keys on the same edge.
        key_n = 4'b0110;
        tick(10);
        check_eq("k03_early", press_pulse, 4'b0000);
        tick(1);
        check_eq("k03_press", press_pulse, 4'b1001);
        check_eq("k03_level", pressed, 4'b1001);
        tick(1);
        check_eq("k03_once", press_pulse, 4'b0000);
        key_n = 4'b1111;
        tick(14);
        check_eq("k03_released", pressed, 4'b0000);

        // Glitch of DEBOUNCE_CYCLES-1 cycles on key3: ignored.
        p_snap = press_cnt[3];
        key_n[3] = 1'b0;
        tick(DB - 1);
        key_n[3] = 1'b1;
        tick(20);
        check_eq("k3_glitch_none", press_cnt[3] - p_snap, 0);
        check_eq("k3_glitch_level", pressed, 4'b0000);

        // Reset in the middle of a press check on key1 (cnt=5), key kept low.
        p_snap = press_cnt[1];
        key_n[1] = 1'b0;
        tick(7);
        rst = 1'b1;
        tick(2);
        check_eq("rst_mid_level", pressed, 4'b0000);
        check_eq("rst_mid_press", press_pulse, 4'b0000);
        rst = 1'b0;
        tick(10);
        check_eq("rst_mid_early", press_pulse, 4'b0000);
        check_eq("rst_mid_none", press_cnt[1] - p_snap, 0);
        tick(1);
        check_eq("rst_mid_press_after", press_pulse, 4'b0010);
        key_n[1] = 1'b1;
        tick(11);
        check_eq("rst_mid_release", release_pulse, 4'b0010);
        tick(3);

`ifdef KEY_AUTOREPEAT_EN
        key_n[0] = 1'b0;
        tick(11);
        check_eq("rep_first", press_pulse[0], 1'b1);
        for (int off = 1; off <= 50; off++) begin
            tick(1);
            check_eq($sformatf("rep_off%0d", off), press_pulse[0],
                     (off >= 20 && ((off - 20) % 6) == 0) ? 1'b1 : 1'b0);
        end
        p_snap = press_cnt[0];
        key_n[0] = 1'b1;
        tick(25);
        check_eq("rep_none_after_rel", press_cnt[0] - p_snap, 0);
        check_eq("rep_rel_level", pressed, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_press_conditioner.md
Name: key_press_conditioner

Overview:
- Input-side counterpart to the lock's display outputs. Takes raw active-low push-button lines from the board and turns each into a clean, debounced signal.
- For each key it produces a level, a one-cycle press pulse and a one-cycle release pulse.
- The lock's getter and FSM confirm/switch inputs consume the press pulses, so one physical press registers as exactly one event.
- Sits between the board wrapper's KEY pins and security_lock_top.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, cycles the synchronized input must be stable before a state change is accepted (20 ms at 50 MHz). Must be ≥2.
- CNT_W, 20, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- i_clk  input  1  system clock (CLOCK_50).
- i_hard_reset  input  1  synchronous, active-high reset.
- i_key_n  input  NUM_KEYS  raw asynchronous button lines; 0 = pressed.
- o_pressed  output  NUM_KEYS  debounced level; 1 = key held.
- o_press_pulse  output  NUM_KEYS  one-cycle strobe on an accepted press.
- o_release_pulse  output  NUM_KEYS  one-cycle strobe on an accepted release.

Behaviour:
- One clock domain (i_clk). Reset is synchronous and active-high on i_hard_reset; it is sampled only on the i_clk rising edge.
- Reset values:
  - Synchronizer flops = 1 (released).
  - All FSMs in RELEASED; all counters = 0.
  - o_pressed = 0, o_press_pulse = 0, o_release_pulse = 0.
- Synchronizer: each bit of i_key_n passes through a 2-FF synchronizer. Only the second stage (s_n) is used downstream.
- Per-key FSM, fully independent per channel; all outputs are registered.
  - RELEASED: if s_n = 0, go to PRESS_CHK and set cnt = 1.
  - PRESS_CHK:
    - if s_n = 1 (bounce), return to RELEASED and set cnt = 0; no pulse.
    - else if cnt = DEBOUNCE_CYCLES-1, go to PRESSED, clear cnt, and assert o_press_pulse for exactly one cycle. o_pressed goes to 1 on the same edge.
    - else cnt increments.
  - PRESSED: if s_n = 1, go to RELEASE_CHK and set cnt = 1.
  - RELEASE_CHK: mirror of PRESS_CHK.
    - a bounce back to 0 returns to PRESSED.
    - on completion go to RELEASED, assert o_release_pulse for one cycle, and set o_pressed to 0.
- Latency: a clean press sampled low at edge k gives o_press_pulse high in the cycle after edge k+DEBOUNCE_CYCLES+2. Total fixed latency is DEBOUNCE_CYCLES+3 cycles. Release latency is identical.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse and no o_pressed change.
- Counter rules: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps. In stable states cnt stays at 0.
- Pulses:
  - o_press_pulse and o_release_pulse are never asserted together on the same bit.
  - A held key gives exactly one press pulse, however long it is held (when the optional feature is off).
- Simultaneous keys: separate channels pressed on the same cycle give their pulses on the same cycle, with no priority or masking between channels.
- Reset mid-operation: any in-progress check is abandoned and no pulse is emitted. A key still held when reset deasserts is re-debounced from RELEASED and yields one press pulse DEBOUNCE_CYCLES+3 cycles after the first post-reset edge.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN. Adds parameters REPEAT_DELAY (default 25000000) and REPEAT_PERIOD (default 5000000).
- Defined:
  - In PRESSED, a per-key repeat counter runs.
  - Extra o_press_pulse strobes fire at REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles while still PRESSED.
  - Leaving PRESSED clears the repeat counter.
  - o_pressed and o_release_pulse are unaffected.
- Undefined: no repeat logic or parameters exist; exactly one press pulse per accepted press.

Test Plan (sim with DEBOUNCE_CYCLES=8, NUM_KEYS=4; KEY_AUTOREPEAT_EN undefined unless stated):
- Reset held 3 cycles with i_key_n=4'b1111 → all outputs 0. Then a clean press of key0 at edge k → o_press_pulse=4'b0001 exactly in the cycle after edge k+10, o_pressed[0]=1 from then on.
- Bounce test: drive key1 low 5 cycles, high 1, low 5, high 1, then low steady → no pulse during the bounces. One press pulse 11 cycles after the final falling edge.
- Hold key2 low for 200 cycles, then release cleanly → exactly one press pulse and one release pulse (11 cycles after the rise). o_pressed[2] falls on the same edge as the release pulse.
- Press key0 and key3 on the same edge → o_press_pulse=4'b1001 in a single cycle.
- Assert i_hard_reset mid-PRESS_CHK (cnt=5) on key1 with the key kept low → no pulse during reset. One press pulse 11 cycles after reset deasserts.
- With KEY_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=6: hold key0 for 50 cycles past the first pulse → pulses at +0, +20, +26, +32, +38, +44, +50; none after release.
